// File: rtl/ysyx_23060187_wbu.sv
// Writeback unit: round-robin arbitration of EXU/LSU results onto the
// register-file write port, plus a per-register pending-write scoreboard
// that IDU queries for RAW hazards.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  PICK_LSU | LSU wins the next cycle in which both sources are valid
//  PICK_EXU | EXU wins the next cycle in which both sources are valid
module ysyx_23060187_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {
        PICK_LSU = 1'b0,
        PICK_EXU = 1'b1
    } pick_t;

    pick_t ptr_q, ptr_d;

    logic                  acc_valid;
    logic [ADDR_WIDTH-1:0] acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;

    logic [CNT_WIDTH-1:0] cnt_q [NREG];
    logic [CNT_WIDTH-1:0] cnt_d [NREG];
    logic                 sb_inc;
    logic                 sb_dec;
    logic                 same_reg;

    // Round-robin pointer register; LSU is favoured out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PICK_LSU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant logic: a lone valid source wins; on contention the pointer decides and then flips.
    always_comb begin
        ptr_d     = ptr_q;
        exu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            if (exu_valid && lsu_valid) begin
                if (ptr_q == PICK_LSU) begin
                    lsu_ready = 1'b1;
                    ptr_d     = PICK_EXU;
                end else begin
                    exu_ready = 1'b1;
                    ptr_d     = PICK_LSU;
                end
            end else begin
                exu_ready = exu_valid;
                lsu_ready = lsu_valid;
            end
        end
    end

    assign acc_valid = exu_ready | lsu_ready;
    assign acc_rd    = lsu_ready ? lsu_rd   : exu_rd;
    assign acc_data  = lsu_ready ? lsu_data : exu_data;

    // Register the accepted result onto the RF write port; x0 results are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= acc_valid && (acc_rd != '0);
            if (acc_valid) begin
                rf_waddr <= acc_rd;
                rf_wdata <= acc_data;
            end
        end
    end

    assign sb_inc   = iss_valid && iss_ready && (iss_rd != '0);
    assign sb_dec   = rf_wen && (rf_waddr != '0);
    assign same_reg = (iss_rd == rf_waddr);

    // Scoreboard next state; a simultaneous inc and dec on one register cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (sb_inc && !(sb_dec && same_reg)) begin
            cnt_d[iss_rd] = cnt_q[iss_rd] + CNT_ONE;
        end
        if (sb_dec && !(sb_inc && same_reg) && (cnt_q[rf_waddr] != '0)) begin
            cnt_d[rf_waddr] = cnt_q[rf_waddr] - CNT_ONE;
        end
    end

    // Scoreboard counters; all outstanding writes are forgotten on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign iss_ready = (cnt_q[iss_rd] != CNT_MAX);
    assign rs1_busy  = (rs1 != '0) && (cnt_q[rs1] != '0);
    assign rs2_busy  = (rs2 != '0) && (cnt_q[rs2] != '0);

    // A writeback for a register with nothing outstanding means the pipeline lost track.
    a_no_dec_at_zero : assert property (@(posedge clk) disable iff (rst)
        sb_dec |-> (cnt_q[rf_waddr] != '0));

endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
// Self-checking bench for the writeback unit: directed scenarios followed by
// randomized traffic checked against a cycle-level behavioural model.
module tb_ysyx_23060187_wbu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        iss_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy, rs2_busy;
    logic        exu_valid = 1'b0;
    logic        exu_ready;
    logic [4:0]  exu_rd = '0;
    logic [31:0] exu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    ysyx_23060187_wbu dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(negedge clk);
    endtask

    task automatic test_reset();
        next(); rst = 1'b1; exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234; #1;
        total++; if (exu_ready !== 1'b0) begin bad++; $display("FAIL reset_exu_ready0: got %b want 0", exu_ready); end
        next(); #1;
        total++; if (exu_ready !== 1'b0) begin bad++; $display("FAIL reset_exu_ready1: got %b want 0", exu_ready); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen); end
        total++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_regs: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); #1;
            total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_rs1_busy[%0d]: got %b want 0", r, rs1_busy); end
        end
        next(); rst = 1'b0; exu_valid = 1'b0; #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_release_wen: got %b want 0", rf_wen); end
    endtask

    task automatic test_single_exu();
        next(); iss_valid = 1'b1; iss_rd = 5'd5; #1;
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL single_iss_ready: got %b want 1", iss_ready); end
        next(); iss_valid = 1'b0; exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF; rs1 = 5'd5; #1;
        total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL single_exu_ready: got %b want 1", exu_ready); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL single_busy_pre: got %b want 1", rs1_busy); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL single_wen_pre: got %b want 0", rf_wen); end
        next(); exu_valid = 1'b0; #1;
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_write: got %b/%0d/%h want 1/5/deadbeef", rf_wen, rf_waddr, rf_wdata); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL single_busy_wen: got %b want 1", rs1_busy); end
        next(); #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL single_wen_after: got %b want 0", rf_wen); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", rs1_busy); end
    endtask

    task automatic test_contention();
        next(); iss_valid = 1'b1; iss_rd = 5'd3;
        next(); iss_rd = 5'd4;
        next(); iss_rd = 5'd4;
        next(); iss_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44; #1;
        total++; if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin bad++; $display("FAIL cont_first_grant: got lsu=%b exu=%b want lsu=1 exu=0", lsu_ready, exu_ready); end
        next(); lsu_data = 32'h45; #1;
        total++; if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin bad++; $display("FAIL cont_second_grant: got lsu=%b exu=%b want lsu=0 exu=1", lsu_ready, exu_ready); end
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin bad++; $display("FAIL cont_write1: got %b/%0d/%h want 1/4/44", rf_wen, rf_waddr, rf_wdata); end
        next(); exu_valid = 1'b0; #1;
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL cont_lone_lsu: got %b want 1", lsu_ready); end
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin bad++; $display("FAIL cont_write2: got %b/%0d/%h want 1/3/33", rf_wen, rf_waddr, rf_wdata); end
        next(); lsu_valid = 1'b0; #1;
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h45) begin bad++; $display("FAIL cont_write3: got %b/%0d/%h want 1/4/45", rf_wen, rf_waddr, rf_wdata); end
        next(); #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL cont_idle: got %b want 0", rf_wen); end
    endtask

    task automatic test_scoreboard();
        for (int k = 0; k < 3; k++) begin
            next(); iss_valid = 1'b1; iss_rd = 5'd7; #1;
            total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL sb_issue%0d_ready: got %b want 1", k, iss_ready); end
        end
        next(); rs1 = 5'd7; #1;
        total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL sb_saturated_ready: got %b want 0", iss_ready); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_busy_sat: got %b want 1", rs1_busy); end
        next(); iss_valid = 1'b0; exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h70; #1;
        total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL sb_wb_ready: got %b want 1", exu_ready); end
        next(); exu_data = 32'h71; #1;
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin bad++; $display("FAIL sb_wb1: got %b/%0d want 1/7", rf_wen, rf_waddr); end
        total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL sb_ready_during_wen: got %b want 0", iss_ready); end
        next(); exu_data = 32'h72; #1;
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL sb_ready_after_wb: got %b want 1", iss_ready); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_busy_cnt2: got %b want 1", rs1_busy); end
        next(); exu_valid = 1'b0; #1;
        total++; if (rf_wen !== 1'b1 || rf_wdata !== 32'h72) begin bad++; $display("FAIL sb_wb3: got %b/%h want 1/72", rf_wen, rf_wdata); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_busy_cnt1: got %b want 1", rs1_busy); end
        next(); #1;
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_busy_clear: got %b want 0", rs1_busy); end
    endtask

    task automatic test_same_cycle();
        next(); iss_valid = 1'b1; iss_rd = 5'd9;
        next(); iss_valid = 1'b0; exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99; #1;
        total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL same_exu_ready: got %b want 1", exu_ready); end
        next(); exu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd9; rs2 = 5'd9; #1;
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9) begin bad++; $display("FAIL same_wen: got %b/%0d want 1/9", rf_wen, rf_waddr); end
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL same_iss_ready: got %b want 1", iss_ready); end
        next(); iss_valid = 1'b0; #1;
        total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL same_rs2_busy: got %b want 1", rs2_busy); end
        next(); exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h9a;
        next(); exu_valid = 1'b0;
        next(); #1;
        total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL same_rs2_drained: got %b want 0", rs2_busy); end
    endtask

    task automatic test_x0();
        next(); lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'd1; iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0; #1;
        total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL x0_lsu_ready: got %b want 1", lsu_ready); end
        next(); lsu_valid = 1'b0; #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_no_wen: got %b want 0", rf_wen); end
        for (int k = 0; k < 4; k++) begin
            next(); #1;
            total++; if (iss_ready !== 1'b1 || rs1_busy !== 1'b0) begin bad++; $display("FAIL x0_no_stall%0d: got ready=%b busy=%b want 1/0", k, iss_ready, rs1_busy); end
        end
        next(); iss_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        next(); iss_valid = 1'b1; iss_rd = 5'd6;
        next(); iss_valid = 1'b0; rst = 1'b1; exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'h66; rs1 = 5'd6; #1;
        total++; if (exu_ready !== 1'b0) begin bad++; $display("FAIL midrst_exu_ready: got %b want 0", exu_ready); end
        total++; if (rs1_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", rs1_busy); end
        next(); rst = 1'b0; exu_valid = 1'b0; #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL midrst_dropped: got %b want 0", rf_wen); end
        total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL midrst_cleared: got %b want 0", rs1_busy); end
    endtask

    task automatic test_random();
        int          cnt_m [32];
        int          pool [$];
        bit          ptr_lsu, ew, ev, lv, g_e, g_l, exp_ir;
        logic [4:0]  ea, er, lr;
        logic [31:0] ed, edat, ldat;
        int          idx;
        next(); rst = 1'b1; iss_valid = 1'b0; exu_valid = 1'b0; lsu_valid = 1'b0;
        next(); rst = 1'b0;
        foreach (cnt_m[i]) cnt_m[i] = 0;
        ptr_lsu = 1'b1; ew = 1'b0; ea = '0; ed = '0; ev = 1'b0; lv = 1'b0;
        er = '0; lr = '0; edat = '0; ldat = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc != 0) next();
            if (!ev && $urandom_range(0, 2) != 0) begin
                if (pool.size() > 0 && $urandom_range(0, 5) != 0) begin
                    idx = $urandom_range(0, pool.size() - 1); er = 5'(pool[idx]); pool.delete(idx);
                end else er = 5'd0;
                edat = $urandom; ev = 1'b1;
            end
            if (!lv && $urandom_range(0, 2) != 0) begin
                if (pool.size() > 0 && $urandom_range(0, 5) != 0) begin
                    idx = $urandom_range(0, pool.size() - 1); lr = 5'(pool[idx]); pool.delete(idx);
                end else lr = 5'd0;
                ldat = $urandom; lv = 1'b1;
            end
            exu_valid = ev; exu_rd = er; exu_data = edat;
            lsu_valid = lv; lsu_rd = lr; lsu_data = ldat;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            #1;
            g_l = lv && (!ev || ptr_lsu);
            g_e = ev && (!lv || !ptr_lsu);
            exp_ir = (cnt_m[iss_rd] < 3);
            total++; if (exu_ready !== g_e || lsu_ready !== g_l) begin bad++; $display("FAIL rnd_grant@%0d: got exu=%b lsu=%b want exu=%b lsu=%b", cyc, exu_ready, lsu_ready, g_e, g_l); end
            total++; if (iss_ready !== exp_ir) begin bad++; $display("FAIL rnd_iss_ready@%0d rd=%0d: got %b want %b", cyc, iss_rd, iss_ready, exp_ir); end
            total++; if (rs1_busy !== (rs1 != 0 && cnt_m[rs1] > 0) || rs2_busy !== (rs2 != 0 && cnt_m[rs2] > 0)) begin bad++; $display("FAIL rnd_busy@%0d: got %b%b for rs1=%0d rs2=%0d", cyc, rs1_busy, rs2_busy, rs1, rs2); end
            total++; if (rf_wen !== ew) begin bad++; $display("FAIL rnd_wen@%0d: got %b want %b", cyc, rf_wen, ew); end
            if (ew) begin
                total++; if (rf_waddr !== ea || rf_wdata !== ed) begin bad++; $display("FAIL rnd_wdata@%0d: got %0d/%h want %0d/%h", cyc, rf_waddr, rf_wdata, ea, ed); end
            end
            if (iss_valid && exp_ir && iss_rd != 0) begin cnt_m[iss_rd]++; pool.push_back(int'(iss_rd)); end
            if (ew && ea != 0) cnt_m[ea]--;
            ew = 1'b0;
            if (g_l) begin ew = (lr != 0); ea = lr; ed = ldat; lv = 1'b0; end
            else if (g_e) begin ew = (er != 0); ea = er; ed = edat; ev = 1'b0; end
            if (g_l && ev) ptr_lsu = 1'b0;
            else if (g_e && lv) ptr_lsu = 1'b1;
        end
        next(); exu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_exu();
        test_contention();
        test_scoreboard();
        test_same_cycle();
        test_x0();
        test_reset_midop();
        test_random();
        next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
